rptr_empty: RTL and testbench
=============================

# rptr_empty

Read-side pointer and empty-flag generator for the dual-clock asynchronous FIFO. It is the read-domain counterpart of the write pointer/full logic. It keeps the binary read address and the Gray-coded read pointer, which the write domain synchronizes. It compares the next read pointer against the write pointer after two-flop synchronization into the read domain, and from that produces registered empty, almost-empty, fill level and sticky underflow status for the consumer.

## Interface
- `ADDRSIZE`, default 4: FIFO address width. Depth is 2^ADDRSIZE. The minimum legal value is 2.
- `rclk`, input, 1: read clock. Every register in the block is clocked on its rising edge.
- `rrst`, input, 1: synchronous reset, active-high, sampled on the rising edge of `rclk`.
- `rinc`, input, 1: read request. It pops one word when `rempty` is 0.
- `rq2_wptr`, input, ADDRSIZE+1: Gray write pointer, already synchronized into `rclk`.
- `rempty`, output, 1: registered. High when the FIFO is empty.
- `arempty`, output, 1: registered. High when exactly one word is readable.
- `raddr`, output, ADDRSIZE: memory read address, equal to `rbin[ADDRSIZE-1:0]`.
- `rptr`, output, ADDRSIZE+1: registered Gray read pointer, sent to the write-domain synchronizer.
- `rlevel`, output, ADDRSIZE+1: registered count of readable words, range 0..2^ADDRSIZE.
- `runderflow`, output, 1: sticky flag. Set by a `rinc` issued while `rempty` is 1.

## Operation
- Internal binary pointer `rbin` has ADDRSIZE+1 bits, including the wrap bit.
- `rbinnext` = `rbin` + (`rinc` & ~`rempty`), modulo 2^(ADDRSIZE+1).
- `rgraynext` = (`rbinnext` >> 1) ^ `rbinnext`.
- `rgraynextp1` is the Gray code of `rbinnext`+1, computed modulo 2^(ADDRSIZE+1).
- Every cycle, {`rbin`, `rptr`} <= {`rbinnext`, `rgraynext`}. `rptr` changes by at most one bit per cycle.
- Empty test: `rempty` <= (`rgraynext` == `rq2_wptr`). The comparison uses all ADDRSIZE+1 bits, with no inversion.
- Almost-empty test: `arempty` <= (`rgraynextp1` == `rq2_wptr`). `arempty` and `rempty` are never both 1.
- Level:
  - `rq2_wbin[i]` = XOR of `rq2_wptr[ADDRSIZE:i]`, for i = ADDRSIZE..0.
  - `rlevel` <= (`rq2_wbin` − `rbinnext`) modulo 2^(ADDRSIZE+1).
  - The full value 2^ADDRSIZE is representable.
- Underflow:
  - `runderflow` <= `runderflow` | (`rinc` & `rempty`).
  - It is cleared only by `rrst`.
  - A blocked `rinc` does not advance any pointer.
- Wrap-around:
  - `rbin` wraps from 2^(ADDRSIZE+1)−1 to 0.
  - `raddr` wraps every 2^ADDRSIZE reads.
  - Level and flag arithmetic stay correct across both wraps.
- Reset, including mid-operation:
  - `rbin`, `rptr`, `rlevel` and `runderflow` go to 0.
  - `rempty` goes to 1.
  - `arempty` goes to 0.
  - `rrst` overrides `rinc` in the same cycle.
- `rq2_wptr` is a legal Gray pointer no more than 2^ADDRSIZE entries ahead of `rbin`. Behaviour for illegal values is unspecified, but the block must not leave reset state incorrectly.

## Timing
- Flags and level are registered: computed from `rbinnext` and `rq2_wptr`, visible in the cycle after the edge.
- A pop:
  - `rinc`=1 with `rempty`=0 at edge N consumes the word at the current `raddr`.
  - `raddr`, `rptr`, `rempty`, `arempty` and `rlevel` all reflect the pop after edge N.
- New data:
  - A change of `rq2_wptr` sampled at edge N deasserts `rempty` after edge N.
  - End to end, write-to-not-empty is 2 `rclk` cycles of synchronizer plus 1 cycle here.
- Simultaneous pop and arrival: `rlevel` after the edge equals old level − 1 + (new writes).
- `rinc` in a cycle where `rempty`=1 is ignored, even if `rq2_wptr` advances in that same cycle.
- Flags are pessimistic: `rempty` may assert late-clear, but must never clear while the FIFO is empty.
- No combinational path from `rinc` to any output.

## Test plan
- **Reset:** hold `rrst`=1 for 2 cycles with random `rinc` → `rempty`=1, `arempty`=0, `rptr`=0, `raddr`=0, `rlevel`=0, `runderflow`=0.
- **One word:**
  - `rq2_wptr`=5'b00001 → next cycle `rempty`=0, `arempty`=1, `rlevel`=1.
  - Then `rinc`=1 for 1 cycle → `raddr`=1, `rptr`=5'b00001, `rempty`=1, `arempty`=0, `rlevel`=0.
- **Full then drain:**
  - `rq2_wptr`=5'b11000 (bin 16) → `rlevel`=16.
  - 16 back-to-back `rinc` → `raddr` walks 0..15 then 0.
  - `rptr` ends at 5'b11000; `arempty` is high only with 1 word left; `rempty`=1 after the 16th read.
- **Wrap:** stream 40 words with the writer staying 3 ahead → `rptr` Gray sequence has one-bit steps, `rlevel` stays 3, no `rempty`.
- **Underflow:**
  - `rinc`=1 while `rempty`=1 → pointer unchanged, `runderflow`=1.
  - `runderflow` stays 1 after later valid reads until `rrst`.
- **Reset mid-stream:** assert `rrst` with `rlevel`=7 and `rinc`=1 → all outputs at reset values the next cycle, with `rempty`=1 regardless of `rq2_wptr`.

Source files
------------

// File: rtl/rptr_empty.sv
//------------------------------------------------------------------------------
// Module   : rptr_empty
// Function : Read-side pointer, empty/almost-empty flags, fill level and
//            sticky underflow for a dual-clock asynchronous FIFO.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rptr_empty #(
  parameter int ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic                rempty,
  output logic                arempty,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0] rlevel_q, rlevel_d;
  logic              rempty_q, rempty_d;
  logic              arempty_q, arempty_d;
  logic              runderflow_q, runderflow_d;
  logic [ADDRSIZE:0] rbinp1;
  logic [ADDRSIZE:0] rgraynextp1;
  logic [ADDRSIZE:0] rq2_wbin;
  logic              pop;

  // Pops are gated by the registered flag, so rinc never reaches an output combinationally.
  assign pop          = rinc & ~rempty_q;
  assign rbin_d       = rbin_q + {{ADDRSIZE{1'b0}}, pop};
  assign rptr_d       = (rbin_d >> 1) ^ rbin_d;
  assign rbinp1       = rbin_d + {{ADDRSIZE{1'b0}}, 1'b1};
  assign rgraynextp1  = (rbinp1 >> 1) ^ rbinp1;

  always_comb begin
    rq2_wbin           = '0;
    rq2_wbin[ADDRSIZE] = rq2_wptr[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      rq2_wbin[i] = rq2_wbin[i+1] ^ rq2_wptr[i];
    end
  end

  assign rempty_d     = (rptr_d == rq2_wptr);
  assign arempty_d    = (rgraynextp1 == rq2_wptr);
  assign rlevel_d     = rq2_wbin - rbin_d;
  assign runderflow_d = runderflow_q | (rinc & rempty_q);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rlevel_q     <= '0;
      rempty_q     <= 1'b1;
      arempty_q    <= 1'b0;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rlevel_q     <= rlevel_d;
      rempty_q     <= rempty_d;
      arempty_q    <= arempty_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign rempty     = rempty_q;
  assign arempty    = arempty_q;
  assign raddr      = rbin_q[ADDRSIZE-1:0];
  assign rptr       = rptr_q;
  assign rlevel     = rlevel_q;
  assign runderflow = runderflow_q;

endmodule

`default_nettype wire

// File: tb/tb_rptr_empty.sv
//------------------------------------------------------------------------------
// Module   : tb_rptr_empty
// Function : Self-checking bench for rptr_empty (vector table, directed
//            corner sequences and randomized traffic against a count model).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rptr_empty;

  localparam int A     = 4;
  localparam int DEPTH = 1 << A;

  logic         rclk = 1'b0;
  logic         rrst;
  logic         rinc;
  logic [A:0]   rq2_wptr;
  logic         rempty, arempty, runderflow;
  logic [A-1:0] raddr;
  logic [A:0]   rptr, rlevel;

  int checks   = 0;
  int failures = 0;

  // Model state: total words written and read as plain integer counts.
  int w_cnt  = 0;
  int m_rd   = 0;
  bit m_empty = 1'b1;
  bit m_aempty = 1'b0;
  int m_level = 0;
  bit m_uf    = 1'b0;

  rptr_empty #(.ADDRSIZE(A)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rinc      (rinc),
    .rq2_wptr  (rq2_wptr),
    .rempty    (rempty),
    .arempty   (arempty),
    .raddr     (raddr),
    .rptr      (rptr),
    .rlevel    (rlevel),
    .runderflow(runderflow)
  );

  always #5 rclk = ~rclk;

  function automatic logic [A:0] gray(input int count);
    logic [A:0] b;
    b = count[A:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, compare 1ns later.
  task automatic step(input bit rst, input bit inc);
    int lvl;
    @(negedge rclk);
    rrst     = rst;
    rinc     = inc;
    rq2_wptr = gray(w_cnt);
    @(posedge rclk);
    if (rst) begin
      m_rd = 0; m_empty = 1'b1; m_aempty = 1'b0; m_level = 0; m_uf = 1'b0;
    end else begin
      if (inc && m_empty) m_uf = 1'b1;
      if (inc && !m_empty) m_rd++;
      lvl      = w_cnt - m_rd;
      m_level  = lvl;
      m_empty  = (lvl == 0);
      m_aempty = (lvl == 1);
    end
    #1;
    check("rempty",     int'(rempty),     int'(m_empty));
    check("arempty",    int'(arempty),    int'(m_aempty));
    check("rlevel",     int'(rlevel),     m_level);
    check("raddr",      int'(raddr),      m_rd % DEPTH);
    check("rptr",       int'(rptr),       int'(gray(m_rd)));
    check("runderflow", int'(runderflow), int'(m_uf));
  endtask

  typedef struct {
    bit         rst;
    bit         inc;
    int         wcnt;
    bit         e_empty;
    bit         e_aempty;
    int         e_level;
    int         e_raddr;
    logic [A:0] e_rptr;
    bit         e_uf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [A:0] prev;
    int         ones;

    rrst = 1'b1; rinc = 1'b0; rq2_wptr = '0;

    vecs[0] = '{1'b1, 1'b1, 0, 1'b1, 1'b0, 0, 0, 5'b00000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 0, 5'b00000, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1, 1'b0, 1'b1, 1, 0, 5'b00000, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 0, 1, 5'b00001, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 0, 1, 5'b00001, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 3, 1'b0, 1'b0, 2, 1, 5'b00001, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 3, 1'b0, 1'b1, 1, 2, 5'b00011, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 3, 1'b1, 1'b0, 0, 0, 5'b00000, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 0, 5'b00000, 1'b0};

    for (int i = 0; i < 9; i++) begin
      @(negedge rclk);
      rrst     = vecs[i].rst;
      rinc     = vecs[i].inc;
      rq2_wptr = gray(vecs[i].wcnt);
      @(posedge rclk);
      #1;
      check($sformatf("vec%0d.rempty", i),     int'(rempty),     int'(vecs[i].e_empty));
      check($sformatf("vec%0d.arempty", i),    int'(arempty),    int'(vecs[i].e_aempty));
      check($sformatf("vec%0d.rlevel", i),     int'(rlevel),     vecs[i].e_level);
      check($sformatf("vec%0d.raddr", i),      int'(raddr),      vecs[i].e_raddr);
      check($sformatf("vec%0d.rptr", i),       int'(rptr),       int'(vecs[i].e_rptr));
      check($sformatf("vec%0d.runderflow", i), int'(runderflow), int'(vecs[i].e_uf));
    end

    // Full then drain: writer 16 ahead, 16 back-to-back reads.
    w_cnt = 0;
    step(1'b1, 1'b0);
    w_cnt = 16;
    step(1'b0, 1'b0);
    check("full.rlevel", int'(rlevel), 16);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
    check("drain.rptr", int'(rptr), int'(5'b11000));
    check("drain.rempty", int'(rempty), 1);
    check("drain.raddr", int'(raddr), 0);

    // Wrap: writer kept 3 ahead for 40 reads, crossing the wrap bit.
    w_cnt = m_rd + 3;
    step(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      prev  = rptr;
      w_cnt = m_rd + 4;
      step(1'b0, 1'b1);
      ones = $countones(prev ^ rptr);
      check("wrap.gray_step", ones, 1);
      check("wrap.rlevel", int'(rlevel), 3);
      check("wrap.rempty", int'(rempty), 0);
    end

    // Underflow: drain, pop while empty, then verify stickiness.
    while (!m_empty) step(1'b0, 1'b1);
    prev = rptr;
    step(1'b0, 1'b1);
    check("uf.rptr_hold", int'(rptr), int'(prev));
    check("uf.set", int'(runderflow), 1);
    w_cnt = m_rd + 2;
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("uf.sticky", int'(runderflow), 1);

    // Reset mid-stream with level 7 and a read pending.
    w_cnt = m_rd + 7;
    step(1'b0, 1'b0);
    check("mid.rlevel", int'(rlevel), 7);
    step(1'b1, 1'b1);
    w_cnt = 0;

    // Randomized traffic within the legal writer lead.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        step(1'b1, 1'($urandom_range(0, 1)));
        w_cnt = 0;
      end else begin
        if (w_cnt - m_rd < DEPTH) w_cnt += $urandom_range(0, 1);
        if (w_cnt - m_rd < DEPTH - 1 && $urandom_range(0, 3) == 0) w_cnt++;
        step(1'b0, 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
